// File: rtl/id_ex_alu_ctrl.sv
// ID/EX pipeline boundary: decodes RV32I instructions into ALU operands and control code,
// registered with stall (hold) and flush (bubble) support.
module id_ex_alu_ctrl #(
  parameter int          XLEN     = 32,
  parameter logic [3:0]  NOP_CTRL = 4'h2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [31:0]     id_instr,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic            stall,
  input  logic            flush,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_alu_a,
  output logic [XLEN-1:0] ex_alu_b,
  output logic [3:0]      ex_alu_control,
  output logic [4:0]      ex_rd,
  output logic            ex_reg_write,
  output logic            ex_illegal
);

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_XOR   = 4'b0011;
  localparam logic [3:0] ALU_SLL   = 4'b0100;
  localparam logic [3:0] ALU_SRL   = 4'b0101;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_SLTU  = 4'b1000;
  localparam logic [3:0] ALU_SRA   = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1011;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic            f7b5;
  logic [4:0]      rd_field;
  logic [XLEN-1:0] imm_i, imm_s, imm_u, imm_shamt;

  assign opcode    = id_instr[6:0];
  assign rd_field  = id_instr[11:7];
  assign f3        = id_instr[14:12];
  assign f7        = id_instr[31:25];
  assign f7b5      = id_instr[30];
  assign imm_i     = {{20{id_instr[31]}}, id_instr[31:20]};
  assign imm_s     = {{20{id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
  assign imm_u     = {id_instr[31:12], 12'b0};
  assign imm_shamt = {27'b0, id_instr[24:20]};

  // f7b5 picks SUB only for register-register ops; immediate ops have no SUBI
  function automatic logic [3:0] alu_code(input logic [2:0] fn3, input logic alt,
                                          input logic is_reg);
    case (fn3)
      3'b000:  alu_code = (is_reg && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_code = ALU_SLL;
      3'b010:  alu_code = ALU_SLT;
      3'b011:  alu_code = ALU_SLTU;
      3'b100:  alu_code = ALU_XOR;
      3'b101:  alu_code = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_code = ALU_OR;
      default: alu_code = ALU_AND;
    endcase
  endfunction

  logic [XLEN-1:0] dec_a, dec_b;
  logic [3:0]      dec_ctrl;
  logic            dec_rw, dec_ill;

  always_comb begin
    dec_a    = '0;
    dec_b    = '0;
    dec_ctrl = NOP_CTRL;
    dec_rw   = 1'b0;
    dec_ill  = 1'b0;
    case (opcode)
      OP_R: begin
        if (f7 == 7'b0000000 || f7 == 7'b0100000) begin
          dec_a    = id_rs1_data;
          dec_b    = id_rs2_data;
          dec_ctrl = alu_code(f3, f7b5, 1'b1);
          dec_rw   = 1'b1;
        end else begin
          dec_ill  = 1'b1;
        end
      end
      OP_I: begin
        dec_a    = id_rs1_data;
        dec_b    = (f3 == 3'b001 || f3 == 3'b101) ? imm_shamt : imm_i;
        dec_ctrl = alu_code(f3, f7b5, 1'b0);
        dec_rw   = 1'b1;
      end
      OP_LUI: begin
        dec_b    = imm_u;
        dec_ctrl = ALU_PASSB;
        dec_rw   = 1'b1;
      end
      OP_AUIPC: begin
        dec_a    = id_pc;
        dec_b    = imm_u;
        dec_ctrl = ALU_ADD;
        dec_rw   = 1'b1;
      end
      OP_JAL, OP_JALR: begin
        dec_a    = id_pc;
        dec_b    = 32'd4;
        dec_ctrl = ALU_ADD;
        dec_rw   = 1'b1;
      end
      OP_LOAD: begin
        dec_a    = id_rs1_data;
        dec_b    = imm_i;
        dec_ctrl = ALU_ADD;
        dec_rw   = 1'b1;
      end
      OP_STORE: begin
        dec_a    = id_rs1_data;
        dec_b    = imm_s;
        dec_ctrl = ALU_ADD;
      end
      OP_BRANCH: begin
        dec_a    = id_rs1_data;
        dec_b    = id_rs2_data;
        dec_ctrl = ALU_SUB;
      end
      default: dec_ill = 1'b1;
    endcase
  end

  logic            valid_q, valid_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]      ctrl_q, ctrl_d;
  logic [4:0]      rd_q, rd_d;
  logic            rw_q, rw_d;
  logic            ill_q, ill_d;

  // flush and an idle decode slot both produce the same bubble as reset
  always_comb begin
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    ctrl_d  = ctrl_q;
    rd_d    = rd_q;
    rw_d    = rw_q;
    ill_d   = ill_q;
    if (flush || (!stall && !id_valid)) begin
      valid_d = 1'b0;
      a_d     = '0;
      b_d     = '0;
      ctrl_d  = NOP_CTRL;
      rd_d    = '0;
      rw_d    = 1'b0;
      ill_d   = 1'b0;
    end else if (!stall) begin
      valid_d = 1'b1;
      a_d     = dec_a;
      b_d     = dec_b;
      ctrl_d  = dec_ctrl;
      rd_d    = rd_field;
      rw_d    = dec_rw && (rd_field != 5'd0);
      ill_d   = dec_ill;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= NOP_CTRL;
      rd_q    <= '0;
      rw_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ctrl_q  <= ctrl_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      ill_q   <= ill_d;
    end
  end

  assign ex_valid       = valid_q;
  assign ex_alu_a       = a_q;
  assign ex_alu_b       = b_q;
  assign ex_alu_control = ctrl_q;
  assign ex_rd          = rd_q;
  assign ex_reg_write   = rw_q;
  assign ex_illegal     = ill_q;

endmodule

// File: tb/tb_id_ex_alu_ctrl.sv
// Directed bench for id_ex_alu_ctrl: hand-encoded RV32I words with hand-computed EX outputs.
module tb_id_ex_alu_ctrl;

  logic        clk = 1'b0;
  logic        rst, id_valid, stall, flush;
  logic [31:0] id_instr, id_pc, id_rs1_data, id_rs2_data;
  logic        ex_valid, ex_reg_write, ex_illegal;
  logic [31:0] ex_alu_a, ex_alu_b;
  logic [3:0]  ex_alu_control;
  logic [4:0]  ex_rd;

  int pass_cnt  = 0;
  int total_cnt = 0;

  id_ex_alu_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_alu_a(ex_alu_a), .ex_alu_b(ex_alu_b),
    .ex_alu_control(ex_alu_control), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  // {valid, a, b, ctrl, rd, reg_write, illegal}
  function automatic logic [75:0] obs();
    return {ex_valid, ex_alu_a, ex_alu_b, ex_alu_control, ex_rd, ex_reg_write, ex_illegal};
  endfunction

  function automatic logic [75:0] ev(logic v, logic [31:0] a, logic [31:0] b, logic [3:0] c,
                                     logic [4:0] rd, logic rw, logic ill);
    return {v, a, b, c, rd, rw, ill};
  endfunction

  localparam logic [75:0] RESET_V = {1'b0, 32'h0, 32'h0, 4'h2, 5'd0, 1'b0, 1'b0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [31:0] instr, logic [31:0] pc, logic [31:0] rs1, logic [31:0] rs2);
    id_valid    = 1'b1;
    id_instr    = instr;
    id_pc       = pc;
    id_rs1_data = rs1;
    id_rs2_data = rs2;
  endtask

  task automatic test_reset();
    logic [75:0] e;
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(32'h002081B3, 32'h0, 32'd5, 32'd7);
    for (int i = 0; i < 2; i++) begin
      tick();
      total_cnt++;
      if (obs() !== RESET_V) $display("FAIL reset_cyc%0d got %h exp %h", i, obs(), RESET_V);
      else pass_cnt++;
    end
    rst = 1'b0;
    tick();
    e = ev(1'b1, 32'd5, 32'd7, 4'b0010, 5'd3, 1'b1, 1'b0);
    total_cnt++;
    if (obs() !== e) $display("FAIL add_after_reset got %h exp %h", obs(), e);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] instrs [4];
    logic [75:0] exps   [4];
    instrs[0] = 32'h40208233;
    exps[0]   = ev(1'b1, 32'd5, 32'd7, 4'b0110, 5'd4, 1'b1, 1'b0);
    instrs[1] = 32'h4030D293;
    exps[1]   = ev(1'b1, 32'd5, 32'd3, 4'b1001, 5'd5, 1'b1, 1'b0);
    instrs[2] = 32'hFFF0B313;
    exps[2]   = ev(1'b1, 32'd5, 32'hFFFFFFFF, 4'b1000, 5'd6, 1'b1, 1'b0);
    instrs[3] = 32'h0030D293;
    exps[3]   = ev(1'b1, 32'd5, 32'd3, 4'b0101, 5'd5, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(instrs[i], 32'h0, 32'd5, 32'd7);
      tick();
      total_cnt++;
      if (obs() !== exps[i]) $display("FAIL b2b_%0d got %h exp %h", i, obs(), exps[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_upper_jump_mem();
    logic [31:0] instrs [5];
    logic [31:0] pcs    [5];
    logic [75:0] exps   [5];
    instrs[0] = 32'h123453B7; pcs[0] = 32'h0;
    exps[0]   = ev(1'b1, 32'h0, 32'h12345000, 4'b1011, 5'd7, 1'b1, 1'b0);
    instrs[1] = 32'h00001417; pcs[1] = 32'h100;
    exps[1]   = ev(1'b1, 32'h100, 32'h1000, 4'b0010, 5'd8, 1'b1, 1'b0);
    instrs[2] = 32'h000000EF; pcs[2] = 32'h200;
    exps[2]   = ev(1'b1, 32'h200, 32'd4, 4'b0010, 5'd1, 1'b1, 1'b0);
    // SW x2,-4(x1): S-imm 0xFFC split across instr[31:25] and instr[11:7]
    instrs[3] = 32'hFE20AE23; pcs[3] = 32'h0;
    exps[3]   = ev(1'b1, 32'd5, 32'hFFFFFFFC, 4'b0010, 5'd28, 1'b0, 1'b0);
    instrs[4] = 32'h00208463; pcs[4] = 32'h0;
    exps[4]   = ev(1'b1, 32'd5, 32'd7, 4'b0110, 5'd8, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(instrs[i], pcs[i], 32'd5, 32'd7);
      tick();
      total_cnt++;
      if (obs() !== exps[i]) $display("FAIL upper_jump_mem_%0d got %h exp %h", i, obs(), exps[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_stall();
    logic [75:0] held, e;
    drive(32'h0080A483, 32'h0, 32'h1000, 32'd7);
    tick();
    held = ev(1'b1, 32'h1000, 32'd8, 4'b0010, 5'd9, 1'b1, 1'b0);
    total_cnt++;
    if (obs() !== held) $display("FAIL load_add got %h exp %h", obs(), held);
    else pass_cnt++;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(32'h40208233 + (i << 7), 32'h0, 32'd20 + i, 32'd3);
      tick();
      total_cnt++;
      if (obs() !== held) $display("FAIL stall_hold_%0d got %h exp %h", i, obs(), held);
      else pass_cnt++;
    end
    stall = 1'b0;
    drive(32'h40208233, 32'h0, 32'd20, 32'd3);
    tick();
    e = ev(1'b1, 32'd20, 32'd3, 4'b0110, 5'd4, 1'b1, 1'b0);
    total_cnt++;
    if (obs() !== e) $display("FAIL stall_release got %h exp %h", obs(), e);
    else pass_cnt++;
    id_valid = 1'b0;
    tick();
    total_cnt++;
    if (obs() !== RESET_V) $display("FAIL idle_bubble got %h exp %h", obs(), RESET_V);
    else pass_cnt++;
  endtask

  task automatic test_flush_rst();
    logic [75:0] e;
    drive(32'h002081B3, 32'h0, 32'd5, 32'd7);
    tick();
    stall = 1'b1; flush = 1'b1;
    tick();
    total_cnt++;
    if (obs() !== RESET_V) $display("FAIL flush_over_stall got %h exp %h", obs(), RESET_V);
    else pass_cnt++;
    stall = 1'b0; flush = 1'b0;
    drive(32'h123453B7, 32'h0, 32'd5, 32'd7);
    tick();
    stall = 1'b1;
    tick();
    e = ev(1'b1, 32'h0, 32'h12345000, 4'b1011, 5'd7, 1'b1, 1'b0);
    total_cnt++;
    if (obs() !== e) $display("FAIL stall_before_rst got %h exp %h", obs(), e);
    else pass_cnt++;
    rst = 1'b1;
    tick();
    total_cnt++;
    if (obs() !== RESET_V) $display("FAIL rst_mid_stall got %h exp %h", obs(), RESET_V);
    else pass_cnt++;
    rst = 1'b0; stall = 1'b0;
  endtask

  task automatic test_illegal();
    logic [31:0] instrs [3];
    logic [75:0] exps   [3];
    instrs[0] = 32'h000000FF;
    exps[0]   = ev(1'b1, 32'h0, 32'h0, 4'b0010, 5'd1, 1'b0, 1'b1);
    instrs[1] = 32'h022081B3;
    exps[1]   = ev(1'b1, 32'h0, 32'h0, 4'b0010, 5'd3, 1'b0, 1'b1);
    instrs[2] = 32'h00000013;
    exps[2]   = ev(1'b1, 32'd5, 32'h0, 4'b0010, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(instrs[i], 32'h0, 32'd5, 32'd7);
      tick();
      total_cnt++;
      if (obs() !== exps[i]) $display("FAIL illegal_rd0_%0d got %h exp %h", i, obs(), exps[i]);
      else pass_cnt++;
    end
  endtask

  initial begin
    id_valid = 1'b0; id_instr = '0; id_pc = '0; id_rs1_data = '0; id_rs2_data = '0;
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    test_reset();
    test_back_to_back();
    test_upper_jump_mem();
    test_stall();
    test_flush_rst();
    test_illegal();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
